regfile_dual_sb: RTL and testbench

Parametrised successor to the core register-file wrapper. It holds an integer bank and an FP bank behind NRD read ports and NWR write ports. Each read port has write-through bypass. A per-register busy scoreboard tracks pending writebacks for issue-stall decisions. It sits between decode/issue (read, busy query, busy set) and the writeback stage (write, busy clear).

---
 rtl/regfile_dual_sb.sv | 156 +++++++++++++++
 tb/tb_regfile_dual_sb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dual_sb.sv
// regfile_dual_sb: integer + FP register banks with NRD combinational read
// ports (write-through bypass), NWR write ports (highest index wins) and a
// per-register busy scoreboard for issue-stall decisions.
module regfile_dual_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 3,
    parameter int NWR  = 2,
    localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD-1:0]      rd_fmode,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR-1:0]      wr_fmode,
    input  logic [NWR*AW-1:0]   wr_idx,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic                iss_fmode,
    input  logic [AW-1:0]       iss_idx,
    input  logic                flush
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
    localparam bit          POW2   = (NREG == (1 << AW));

    // Index is backed by a real register (only matters for non-power-of-two NREG).
    function automatic logic in_range(input logic [AW-1:0] idx);
        if (POW2) return 1'b1;
        return ({1'b0, idx} < NREG_W);
    endfunction

    // Integer x0 is hardwired: never written, never busy.
    function automatic logic is_x0(input logic fmode, input logic [AW-1:0] idx);
        return (!fmode) && (idx == '0);
    endfunction

    logic [XLEN-1:0] regs_q [2][NREG];
    logic [XLEN-1:0] regs_d [2][NREG];
    logic [NREG-1:0] busy_q [2];
    logic [NREG-1:0] busy_d [2];

    logic [NWR-1:0]  wr_ok;
    logic            iss_ok;

    // A write port is effective only if enabled, in range and not aimed at x0.
    genvar gi;
    generate
        for (gi = 0; gi < NWR; gi++) begin : g_wr_ok
            assign wr_ok[gi] = wr_en[gi]
                             && in_range(wr_idx[gi*AW +: AW])
                             && !is_x0(wr_fmode[gi], wr_idx[gi*AW +: AW]);
        end
    endgenerate

    assign iss_ok = iss_en && in_range(iss_idx) && !is_x0(iss_fmode, iss_idx);

    // Next register contents: ascending port order so the highest port wins.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < NREG; r++) begin
                regs_d[b][r] = regs_q[b][r];
            end
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_ok[w]) begin
                regs_d[wr_fmode[w]][wr_idx[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    regs_q[b][r] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    regs_q[b][r] <= regs_d[b][r];
                end
            end
        end
    end

    // Scoreboard next state: writebacks clear, then issue sets (a fresh
    // pending write supersedes the one completing), flush clears everything.
    always_comb begin
        busy_d[0] = busy_q[0];
        busy_d[1] = busy_q[1];
        for (int w = 0; w < NWR; w++) begin
            if (wr_ok[w]) begin
                busy_d[wr_fmode[w]][wr_idx[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_d[iss_fmode][iss_idx] = 1'b1;
        end
        if (flush) begin
            busy_d[0] = '0;
            busy_d[1] = '0;
        end
    end

    // Scoreboard storage with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q[0] <= '0;
            busy_q[1] <= '0;
        end else begin
            busy_q[0] <= busy_d[0];
            busy_q[1] <= busy_d[1];
        end
    end

    // Read ports: stored value, overridden by a matching same-cycle write so
    // decode sees the freshest data and a busy flag consistent with it.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   port_idx;
            logic            port_fm;
            logic [XLEN-1:0] port_data;
            logic            port_busy;

            assign port_idx = rd_idx[gi*AW +: AW];
            assign port_fm  = rd_fmode[gi];

            // Combinational read with bypass; outputs held at 0 during reset.
            always_comb begin
                port_data = '0;
                port_busy = 1'b0;
                if (rstn && in_range(port_idx) && !is_x0(port_fm, port_idx)) begin
                    port_data = regs_q[port_fm][port_idx];
                    port_busy = busy_q[port_fm][port_idx];
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_ok[w] && (wr_fmode[w] == port_fm)
                                     && (wr_idx[w*AW +: AW] == port_idx)) begin
                            port_data = wr_data[w*XLEN +: XLEN];
                            port_busy = 1'b0;
                        end
                    end
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = port_data;
            assign rd_busy[gi]              = port_busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_dual_sb.sv
// Self-checking bench for regfile_dual_sb: directed scenarios plus a
// randomized run against a simple array-based reference model.
module tb_regfile_dual_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rstn;
    logic [NRD-1:0]      rd_fmode;
    logic [NRD*AW-1:0]   rd_idx;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR-1:0]      wr_fmode;
    logic [NWR*AW-1:0]   wr_idx;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic                iss_fmode;
    logic [AW-1:0]       iss_idx;
    logic                flush;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_reg  [2][NREG];
    logic            m_busy [2][NREG];

    regfile_dual_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rstn(rstn),
        .rd_fmode(rd_fmode), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_fmode(wr_fmode), .wr_idx(wr_idx), .wr_data(wr_data),
        .iss_en(iss_en), .iss_fmode(iss_fmode), .iss_idx(iss_idx), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NREG; r++) begin
                m_reg[b][r]  = '0;
                m_busy[b][r] = 1'b0;
            end
    endfunction

    // Expected read data for port p given current inputs and model state.
    function automatic logic [XLEN-1:0] exp_data(input int p);
        int b = int'(rd_fmode[p]);
        int i = int'(rd_idx[p*AW +: AW]);
        if (b == 0 && i == 0) return '0;
        for (int w = NWR-1; w >= 0; w--)
            if (wr_en[w] && int'(wr_fmode[w]) == b && int'(wr_idx[w*AW +: AW]) == i)
                return wr_data[w*XLEN +: XLEN];
        return m_reg[b][i];
    endfunction

    function automatic logic exp_busy(input int p);
        int b = int'(rd_fmode[p]);
        int i = int'(rd_idx[p*AW +: AW]);
        if (b == 0 && i == 0) return 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_fmode[w]) == b && int'(wr_idx[w*AW +: AW]) == i)
                return 1'b0;
        return m_busy[b][i];
    endfunction

    // Apply this cycle's inputs to the model, then advance one clock.
    task automatic tick();
        for (int w = 0; w < NWR; w++) begin
            int b = int'(wr_fmode[w]);
            int i = int'(wr_idx[w*AW +: AW]);
            if (wr_en[w] && !(b == 0 && i == 0)) m_reg[b][i] = wr_data[w*XLEN +: XLEN];
        end
        for (int w = 0; w < NWR; w++)
            if (wr_en[w]) m_busy[wr_fmode[w]][wr_idx[w*AW +: AW]] = 1'b0;
        if (iss_en && !(iss_fmode == 1'b0 && iss_idx == '0)) m_busy[iss_fmode][iss_idx] = 1'b1;
        if (flush) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < NREG; r++) m_busy[b][r] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_fmode = '0; wr_idx = '0; wr_data = '0;
        iss_en = 1'b0; iss_fmode = 1'b0; iss_idx = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic f, input logic [AW-1:0] i);
        rd_fmode[p] = f;
        rd_idx[p*AW +: AW] = i;
    endtask

    task automatic set_wr(input int w, input logic f, input logic [AW-1:0] i, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1;
        wr_fmode[w] = f;
        wr_idx[w*AW +: AW] = i;
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        rd_fmode = '0; rd_idx = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #7;
        set_rd(0, 1'b0, 5'd5); set_rd(1, 1'b1, 5'd5); set_rd(2, 1'b1, 5'd5);
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            errors++;
            $display("FAIL reset_held: data=%h busy=%b required 0/0", rd_data, rd_busy);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*XLEN +: XLEN] !== 32'h0 || rd_busy[p] !== 1'b0) begin
                errors++;
                $display("FAIL reset_read port%0d: data=%h busy=%b required 0/0", p, rd_data[p*XLEN +: XLEN], rd_busy[p]);
            end
        end
    endtask

    task automatic test_write_bypass();
        idle();
        set_wr(0, 1'b0, 5'd3, 32'hDEADBEEF);
        set_rd(0, 1'b0, 5'd3); set_rd(1, 1'b1, 5'd3); set_rd(2, 1'b0, 5'd3);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_x3: got %h required DEADBEEF", rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stored_x3: got %h required DEADBEEF", rd_data[31:0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL fp_f3_separate: got %h required 00000000", rd_data[63:32]);
        end
        tick();
    endtask

    task automatic test_bank_x0();
        idle();
        set_wr(0, 1'b0, 5'd0, 32'h00001234);
        set_wr(1, 1'b1, 5'd0, 32'h3F800000);
        set_rd(0, 1'b0, 5'd0); set_rd(1, 1'b1, 5'd0); set_rd(2, 1'b0, 5'd0);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: got %h required 00000000", rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL x0_stored: got %h required 00000000", rd_data[31:0]);
        end
        checks++;
        if (rd_data[63:32] !== 32'h3F800000) begin
            errors++;
            $display("FAIL f0_stored: got %h required 3F800000", rd_data[63:32]);
        end
        iss_en = 1'b1; iss_fmode = 1'b0; iss_idx = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: got %b required 0", rd_busy[0]);
        end
    endtask

    task automatic test_priority();
        idle();
        set_wr(0, 1'b1, 5'd7, 32'hAAAA0000);
        set_wr(1, 1'b1, 5'd7, 32'h5555FFFF);
        set_rd(0, 1'b1, 5'd7); set_rd(1, 1'b1, 5'd7); set_rd(2, 1'b0, 5'd7);
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h5555FFFF) begin
            errors++;
            $display("FAIL prio_bypass: got %h required 5555FFFF", rd_data[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h5555FFFF) begin
            errors++;
            $display("FAIL prio_stored: got %h required 5555FFFF", rd_data[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        set_rd(0, 1'b0, 5'd9); set_rd(1, 1'b0, 5'd9); set_rd(2, 1'b1, 5'd9);
        iss_en = 1'b1; iss_fmode = 1'b0; iss_idx = 5'd9;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL busy_same_cycle: got %b required 0", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL busy_set: got x9=%b f9=%b required 1/0", rd_busy[0], rd_busy[2]);
        end
        set_wr(0, 1'b0, 5'd9, 32'h00000042);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h42) begin
            errors++;
            $display("FAIL writeback: busy=%b data=%h required 0/00000042", rd_busy[0], rd_data[31:0]);
        end
        tick();
        idle();
        iss_en = 1'b1; iss_fmode = 1'b0; iss_idx = 5'd9;
        set_wr(1, 1'b0, 5'd9, 32'h00000077);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL set_beats_clear: busy=%b data=%h required 1/00000077", rd_busy[0], rd_data[31:0]);
        end
    endtask

    task automatic test_flush_reset();
        idle();
        iss_en = 1'b1; iss_fmode = 1'b1; iss_idx = 5'd1; tick();
        iss_idx = 5'd2; tick();
        iss_fmode = 1'b0; iss_idx = 5'd4; tick();
        idle();
        set_rd(0, 1'b1, 5'd1); set_rd(1, 1'b1, 5'd2); set_rd(2, 1'b0, 5'd4);
        #1;
        checks++;
        if (rd_busy !== 3'b111) begin
            errors++;
            $display("FAIL busy_before_flush: got %b required 111", rd_busy);
        end
        flush = 1'b1; iss_en = 1'b1; iss_fmode = 1'b0; iss_idx = 5'd5;
        set_wr(0, 1'b1, 5'd12, 32'hCAFE0012);
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy !== 3'b000) begin
            errors++;
            $display("FAIL flush_clear: got %b required 000", rd_busy);
        end
        set_rd(0, 1'b0, 5'd5); set_rd(1, 1'b1, 5'd12);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[63:32] !== 32'hCAFE0012) begin
            errors++;
            $display("FAIL flush_iss_write: x5 busy=%b f12=%h required 0/CAFE0012", rd_busy[0], rd_data[63:32]);
        end
        // Asynchronous reset pulse between clock edges.
        set_rd(0, 1'b0, 5'd9); set_rd(2, 1'b1, 5'd7);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL async_reset_held: got %h required 0", rd_data);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            errors++;
            $display("FAIL async_reset_after: data=%h busy=%b required 0/0", rd_data, rd_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            for (int p = 0; p < NRD; p++)
                set_rd(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            iss_en    = ($urandom_range(0, 1) == 1);
            iss_fmode = 1'($urandom_range(0, 1));
            iss_idx   = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*XLEN +: XLEN] !== exp_data(p) || rd_busy[p] !== exp_busy(p)) begin
                    errors++;
                    $display("FAIL rand_read n=%0d port%0d: data=%h busy=%b required %h/%b",
                             n, p, rd_data[p*XLEN +: XLEN], rd_busy[p], exp_data(p), exp_busy(p));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_bank_x0();
        test_priority();
        test_scoreboard();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
